// File: rtl/tracking_output_writer.sv
// tracking_output_writer: after a tracker frame, walks the object register file and writes
// each bounding box to SRAM as a two-word record, then writes a header word at the base address.
module tracking_output_writer #(
    parameter int unsigned  NUM_OBJECTS  = 8,
    parameter int unsigned  ADDR_WIDTH   = 18,
    parameter int unsigned  COORD_WIDTH  = 10,
    parameter bit           SKIP_INVALID = 1'b1,
    localparam int unsigned SelW         = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pause,
    input  logic                   enable_tracking_output,
    input  logic [ADDR_WIDTH-1:0]  base_address,
    input  logic                   mem_busy,
    input  logic                   obj_valid,
    input  logic [COORD_WIDTH-1:0] obj_x_min,
    input  logic [COORD_WIDTH-1:0] obj_x_max,
    input  logic [COORD_WIDTH-1:0] obj_y_min,
    input  logic [COORD_WIDTH-1:0] obj_y_max,
    output logic [SelW-1:0]        obj_sel,
    output logic                   wren,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic [31:0]            data_write,
    output logic                   tracking_output_done
);

    localparam int unsigned CntW = $clog2(NUM_OBJECTS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StWr0,
        StWr1,
        StHeader,
        StDone
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [SelW-1:0]       slot_q;
    logic [CntW-1:0]       count_q;
    logic [15:0]           frame_q;
    logic                  valid_q;
    logic [14:0]           x_max_q;
    logic [15:0]           y_max_q;

    logic [SelW-1:0]       obj_sel_q;
    logic                  wren_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  done_q;

    logic [ADDR_WIDTH-1:0] rec_off;
    logic [ADDR_WIDTH-1:0] wr0_addr;
    logic [ADDR_WIDTH-1:0] wr1_addr;
    logic [CntW-1:0]       count_inc;
    logic [SelW-1:0]       slot_next;
    logic [15:0]           x_min_ext;
    logic [15:0]           y_min_ext;
    logic [14:0]           x_max_ext;
    logic [15:0]           y_max_ext;
    logic [15:0]           count_ext;
    logic [15:0]           count_inc_ext;
    logic                  last_slot;
    logic                  accept;
    logic                  abort;

    // Record addresses, field extension and handshake qualifiers.
    always_comb begin
        rec_off       = ADDR_WIDTH'({count_q, 1'b0});
        wr0_addr      = base_q + rec_off + ADDR_WIDTH'(1);
        wr1_addr      = base_q + rec_off + ADDR_WIDTH'(2);
        count_inc     = count_q + CntW'(1);
        slot_next     = slot_q + SelW'(1);
        x_min_ext     = 16'(obj_x_min);
        y_min_ext     = 16'(obj_y_min);
        // Bit 15 of the x_max half-word carries the valid flag.
        x_max_ext     = 15'(obj_x_max);
        y_max_ext     = 16'(obj_y_max);
        count_ext     = 16'(count_q);
        count_inc_ext = 16'(count_inc);
        last_slot     = (slot_q == SelW'(NUM_OBJECTS - 1));
        accept        = wren_q && !mem_busy;
        abort         = !enable_tracking_output && (state_q != StIdle) && (state_q != StDone);
    end

    // Sequencer: run control, slot walk and the registered SRAM write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            base_q    <= '0;
            slot_q    <= '0;
            count_q   <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            x_max_q   <= '0;
            y_max_q   <= '0;
            obj_sel_q <= '0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else if (pause) begin
            // Everything holds; the pending write is re-issued unchanged on resume.
            wren_q <= 1'b0;
        end else if (abort) begin
            state_q <= StIdle;
            wren_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wren_q <= 1'b0;
                    if (!enable_tracking_output) begin
                        done_q <= 1'b0;
                    end else if (!done_q) begin
                        base_q    <= base_address;
                        slot_q    <= '0;
                        count_q   <= '0;
                        obj_sel_q <= '0;
                        state_q   <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    valid_q <= obj_valid;
                    x_max_q <= x_max_ext;
                    y_max_q <= y_max_ext;
                    if (SKIP_INVALID && !obj_valid) begin
                        if (last_slot) begin
                            state_q <= StHeader;
                            wren_q  <= 1'b1;
                            addr_q  <= base_q;
                            data_q  <= {frame_q, count_ext};
                        end else begin
                            state_q   <= StFetch;
                            slot_q    <= slot_next;
                            obj_sel_q <= slot_next;
                        end
                    end else begin
                        state_q <= StWr0;
                        wren_q  <= 1'b1;
                        addr_q  <= wr0_addr;
                        data_q  <= {x_min_ext, y_min_ext};
                    end
                end
                StWr0: begin
                    wren_q <= 1'b1;
                    if (accept) begin
                        state_q <= StWr1;
                        addr_q  <= wr1_addr;
                        data_q  <= {valid_q, x_max_q, y_max_q};
                    end
                end
                StWr1: begin
                    wren_q <= 1'b1;
                    if (accept) begin
                        count_q <= count_inc;
                        if (last_slot) begin
                            state_q <= StHeader;
                            addr_q  <= base_q;
                            data_q  <= {frame_q, count_inc_ext};
                        end else begin
                            state_q   <= StFetch;
                            wren_q    <= 1'b0;
                            slot_q    <= slot_next;
                            obj_sel_q <= slot_next;
                        end
                    end
                end
                StHeader: begin
                    wren_q <= 1'b1;
                    if (accept) begin
                        state_q <= StDone;
                        wren_q  <= 1'b0;
                        frame_q <= frame_q + 16'd1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign obj_sel              = obj_sel_q;
    assign wren                 = wren_q;
    assign address              = addr_q;
    assign data_write           = data_q;
    assign tracking_output_done = done_q;

endmodule

// File: tb/tb_tracking_output_writer.sv
// Bench for tracking_output_writer: tracker register-file model, SRAM write scoreboard.
module tb_tracking_output_writer;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 18;
    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pause = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic          mem_busy = 1'b0;
    logic          obj_valid = 1'b0;
    logic [CW-1:0] obj_x_min = '0;
    logic [CW-1:0] obj_x_max = '0;
    logic [CW-1:0] obj_y_min = '0;
    logic [CW-1:0] obj_y_max = '0;
    logic [1:0]    obj_sel;
    logic          wren;
    logic [AW-1:0] address;
    logic [31:0]   data_write;
    logic          done;

    tracking_output_writer #(
        .NUM_OBJECTS (N),
        .ADDR_WIDTH  (AW),
        .COORD_WIDTH (CW),
        .SKIP_INVALID(1'b1)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .pause                 (pause),
        .enable_tracking_output(enable),
        .base_address          (base_address),
        .mem_busy              (mem_busy),
        .obj_valid             (obj_valid),
        .obj_x_min             (obj_x_min),
        .obj_x_max             (obj_x_max),
        .obj_y_min             (obj_y_min),
        .obj_y_max             (obj_y_max),
        .obj_sel               (obj_sel),
        .wren                  (wren),
        .address               (address),
        .data_write            (data_write),
        .tracking_output_done  (done)
    );

    always #5 clk = ~clk;

    // Tracker register file: data follows obj_sel with one cycle of latency.
    logic [CW-1:0] tx_min [N];
    logic [CW-1:0] tx_max [N];
    logic [CW-1:0] ty_min [N];
    logic [CW-1:0] ty_max [N];
    logic          tvalid [N];

    always @(posedge clk) begin
        obj_valid <= tvalid[obj_sel];
        obj_x_min <= tx_min[obj_sel];
        obj_x_max <= tx_max[obj_sel];
        obj_y_min <= ty_min[obj_sel];
        obj_y_max <= ty_max[obj_sel];
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wren_cycles = 0;
    int          last_acc_cyc = 0;
    int          exp_k = 0;
    logic [15:0] fc_model = '0;
    logic [49:0] sb_q [$];
    logic [63:0] mon_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every accepted write is matched against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && wren) begin
            wren_cycles++;
            if (!mem_busy) begin
                if (sb_q.size() > 0) mon_exp = {14'b0, sb_q.pop_front()};
                else mon_exp = '1;
                check_eq("sram_write", {14'b0, address, data_write}, mon_exp);
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input logic [N-1:0] vmask);
        for (int i = 0; i < N; i++) begin
            tvalid[i] = vmask[i];
            tx_min[i] = CW'($urandom_range(0, 1023));
            tx_max[i] = CW'($urandom_range(0, 1023));
            ty_min[i] = CW'($urandom_range(0, 1023));
            ty_max[i] = CW'($urandom_range(0, 1023));
        end
    endtask

    task automatic push_run(input logic [AW-1:0] base);
        int            k;
        logic [AW-1:0] a;
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (tvalid[i]) begin
                a = base + AW'(1 + 2 * k);
                sb_q.push_back({a, 6'b0, tx_min[i], 6'b0, ty_min[i]});
                a = base + AW'(2 + 2 * k);
                sb_q.push_back({a, tvalid[i], 5'b0, tx_max[i], 6'b0, ty_max[i]});
                k++;
            end
        end
        sb_q.push_back({base, fc_model, 16'(k)});
        fc_model = fc_model + 16'd1;
        exp_k = k;
    endtask

    task automatic start_run(input logic [AW-1:0] base);
        push_run(base);
        wren_cycles  = 0;
        base_address = base;
        enable       = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_done_latency"}, 64'(cyc - last_acc_cyc), 64'd2);
        check_eq({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic end_run(input string tag);
        enable = 1'b0;
        tick();
        tick();
        check_eq({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    task automatic wait_write(input string tag, input logic [AW-1:0] a);
        int   n;
        logic found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            tick();
            found = wren && (address == a);
            n++;
        end
        check_eq({tag, "_reach"}, 64'(found), 64'd1);
    endtask

    logic [AW-1:0] a0;
    logic [31:0]   d0;

    initial begin
        repeat (3) tick();
        check_eq("rst_wren", 64'(wren), 64'd0);
        check_eq("rst_addr", 64'(address), 64'd0);
        check_eq("rst_data", 64'(data_write), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_obj_sel", 64'(obj_sel), 64'd0);
        reset_n = 1'b1;
        tick();

        // All slots valid.
        load_table(4'b1111);
        start_run(18'h00100);
        wait_done("all_valid");
        check_eq("all_valid_wren_cycles", 64'(wren_cycles), 64'(2 * exp_k + 1));
        wren_cycles = 0;
        repeat (8) tick();
        check_eq("held_enable_no_rerun", 64'(wren_cycles), 64'd0);
        check_eq("held_enable_done", 64'(done), 64'd1);
        end_run("all_valid");

        // Slots 1 and 3 invalid.
        load_table(4'b0101);
        start_run(18'h00200);
        wait_done("skip");
        check_eq("skip_wren_cycles", 64'(wren_cycles), 64'(2 * exp_k + 1));
        end_run("skip");

        // Back-pressure during WR1 of slot 0.
        load_table(4'b1111);
        start_run(18'h00300);
        wait_write("bp", 18'h00302);
        mem_busy = 1'b1;
        a0 = address;
        d0 = data_write;
        repeat (3) begin
            tick();
            check_eq("bp_wren", 64'(wren), 64'd1);
            check_eq("bp_addr_stable", 64'(address), 64'(a0));
            check_eq("bp_data_stable", 64'(data_write), 64'(d0));
        end
        mem_busy = 1'b0;
        wait_done("bp");
        check_eq("bp_wren_cycles", 64'(wren_cycles), 64'(2 * exp_k + 1 + 3));
        end_run("bp");

        // Pause during WR0 of slot 1, raised together with mem_busy.
        load_table(4'b1111);
        start_run(18'h00400);
        wait_write("pause", 18'h00403);
        pause    = 1'b1;
        mem_busy = 1'b1;
        a0 = address;
        d0 = data_write;
        repeat (5) begin
            tick();
            check_eq("pause_wren_low", 64'(wren), 64'd0);
            check_eq("pause_addr_hold", 64'(address), 64'(a0));
            check_eq("pause_data_hold", 64'(data_write), 64'(d0));
        end
        pause    = 1'b0;
        mem_busy = 1'b0;
        tick();
        check_eq("resume_wren", 64'(wren), 64'd1);
        check_eq("resume_addr", 64'(address), 64'(a0));
        check_eq("resume_data", 64'(data_write), 64'(d0));
        wait_done("pause");
        end_run("pause");

        // Base at the top of the address space.
        load_table(4'b1111);
        start_run(18'h3FFFF);
        wait_done("wrap");
        check_eq("wrap_wren_cycles", 64'(wren_cycles), 64'(2 * exp_k + 1));
        end_run("wrap");

        // Abort mid-run: no header, frame count untouched.
        load_table(4'b1111);
        start_run(18'h00500);
        wait_write("abort", 18'h00503);
        enable = 1'b0;
        tick();
        check_eq("abort_wren", 64'(wren), 64'd0);
        repeat (4) tick();
        check_eq("abort_done", 64'(done), 64'd0);
        sb_q.delete();
        fc_model = fc_model - 16'd1;

        load_table(4'b0110);
        start_run(18'h00600);
        wait_done("post_abort");
        end_run("post_abort");

        // Asynchronous reset mid-run.
        load_table(4'b1111);
        start_run(18'h00700);
        repeat (6) tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_wren", 64'(wren), 64'd0);
        check_eq("midrst_addr", 64'(address), 64'd0);
        check_eq("midrst_data", 64'(data_write), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_obj_sel", 64'(obj_sel), 64'd0);
        sb_q.delete();
        fc_model = '0;
        enable   = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        load_table(4'b1011);
        start_run(18'h00800);
        wait_done("post_reset");
        end_run("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tracking_output_writer.md
# tracking_output_writer

Parametrised successor to the tracking output assembly stage. After the tracker finishes a frame, this block reads up to NUM_OBJECTS per-object bounding-box records from the tracker's register file. It packs each record into 32-bit words and writes them, followed by a header word, into external SRAM at a programmable base address. It honours the global `pause`, waits on memory back-pressure, can skip invalid objects, and reports completion on `tracking_output_done`.

## Interface
- NUM_OBJECTS, 8: object slots scanned per run (1..256).
- ADDR_WIDTH, 18: SRAM word-address width.
- COORD_WIDTH, 10: coordinate width (≤16), zero-extended into 16-bit fields.
- SKIP_INVALID, 1: 1 = do not write records whose `obj_valid`=0; 0 = write every slot.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pause  in  1  global stall; 1 freezes the block.
- enable_tracking_output  in  1  run request (level).
- base_address  in  ADDR_WIDTH  header location; records follow. Sampled at run start.
- mem_busy  in  1  SRAM not accepting; a write completes only on an edge where wren=1 and mem_busy=0.
- obj_valid  in  1  record valid flag for slot `obj_sel`.
- obj_x_min, obj_x_max, obj_y_min, obj_y_max  in  COORD_WIDTH each  bounding box for slot `obj_sel`.
- obj_sel  out  clog2(NUM_OBJECTS) (min 1)  slot index presented to the tracker register file.
- wren  out  1  SRAM write enable.
- address  out  ADDR_WIDTH  SRAM word address.
- data_write  out  32  SRAM write data.
- tracking_output_done  out  1  run complete (level).

## Operation
- **States:** IDLE, FETCH, LATCH, WR0, WR1, HEADER, DONE.
- **IDLE**
  - enable=1 and done=0 → latch base_address, clear slot index i and written count k, go to FETCH.
  - enable=0 → clear done.
- **FETCH:** drive obj_sel=i for one cycle. Tracker data is valid one cycle after obj_sel changes.
- **LATCH:** capture obj_* into internal registers.
  - If SKIP_INVALID=1 and obj_valid=0: skip this slot.
  - Otherwise go to WR0.
- **WR0:** address = base+1+2k; data = {x_min zero-extended to 16, y_min zero-extended to 16}.
- **WR1:** address = base+2+2k; data = {obj_valid, 15'b0 padding on x_max to 16 with bit 15 = valid, y_max zero-extended to 16}. Precisely:
  - [31] = obj_valid
  - [30:16] = x_max zero-extended
  - [15:0] = y_max zero-extended
  - Increment k after the WR1 write is accepted.
- **Advance:** after a skip or a completed WR1, if i = NUM_OBJECTS−1 go to HEADER, else i+1 and go to FETCH.
- **HEADER:** address = base; data = {frame_count[15:0], k zero-extended to 16}. When accepted, frame_count+1 (16-bit wrap), go to DONE.
- **DONE:** done=1. Return to IDLE on the same edge. Done stays 1 until enable=0 is sampled in IDLE, which prevents a re-run on a held enable.
- **Address arithmetic:** modulo 2^ADDR_WIDTH (wraps past max).
- **Abort:** enable=0 sampled in any state other than IDLE/DONE:
  - wren=0, return to IDLE next edge.
  - No header is written, done stays 0, frame_count is unchanged.
- **Pause:** pause=1 sampled → state, i, k, address and data hold, and wren=0 on the next edge. On resume, wren reasserts with identical address/data. Pause overrides abort.
- **Reset:** reset_n=0 immediately forces IDLE and all outputs/counters to reset values, including mid-run.

## Timing
- **Reset values:** wren=0, address=0, data_write=0, tracking_output_done=0, obj_sel=0, frame_count=0.
- **Registered outputs:** all outputs registered; no combinational input→output paths.
- **Write handshake:** wren/address/data asserted on entering WR0/WR1/HEADER and held unchanged while mem_busy=1. Each write is accepted exactly once.
- **Throughput:** with no pause or busy, a written slot costs 4 cycles (FETCH, LATCH, WR0, WR1) and a skipped slot costs 2. HEADER takes 1 cycle; done rises on the edge after header acceptance.
- **Write count:** wren is high for exactly 2k+1 cycles per unstalled run.
- **Simultaneous events:** mem_busy=1 with pause=1 → pause wins (wren drops). reset_n wins over everything.

## Test plan
- **All valid:** NUM_OBJECTS=4, SKIP_INVALID=1, all valid, base=0x100, mem_busy=0 → 9 writes: 0x101..0x108 records, then 0x100 = 0x00000004. Done rises 1 cycle after header; wren high 9 cycles.
- **Skip invalid:** slots 1 and 3 invalid, SKIP_INVALID=1 → records only for slots 0,2 at 0x101..0x104; header = 0x00000002.
- **Back-pressure:** mem_busy=1 for 3 cycles during WR1 of slot 0 → address/data stable for 4 cycles, single write recorded, totals unchanged.
- **Pause:** pause=1 for 5 cycles mid-WR0 → wren=0 during pause, same address/data on resume. Reset_n low mid-run → outputs 0 immediately, IDLE.
- **Wrap and frame count:** base=0x3FFFF → records wrap to 0x00000 upward. Two consecutive runs with enable toggled → header frame fields 0 then 1. Abort mid-run via enable=0 → no header, frame_count unchanged.
